// File: rtl/matriz_scan.sv
// Column scanner for the 5x7 irrigation-panel LED matrix: one column per scan tick,
// showing the glyph of the irrigation mode latched at the last frame boundary.
module matriz_scan #(
   parameter int N_COL       = 5,
   parameter int N_LIN       = 7,
   parameter int SYNC_STAGES = 2,
   parameter bit COL_ACT_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             freq_matriz,
   input  logic             gotejamento,
   input  logic             aspersao,
   output logic [N_COL-1:0] coluna,
   output logic [N_LIN-1:0] linha,
   output logic [1:0]       modo,
   output logic             frame_done
);

   localparam int                CW       = (N_COL > 1) ? $clog2(N_COL) : 1;
   localparam logic [CW-1:0]     LAST_COL = CW'(N_COL - 1);
   localparam logic [N_COL-1:0]  COL_OFF  = COL_ACT_LOW ? '1 : '0;

   // Glyph columns, entry 0 = leftmost column, bit0 = top row.
   localparam logic [4:0][6:0] G_TAB = {7'h7A, 7'h49, 7'h49, 7'h41, 7'h3E};
   localparam logic [4:0][6:0] A_TAB = {7'h7E, 7'h09, 7'h09, 7'h09, 7'h7E};
   localparam logic [4:0][6:0] X_TAB = {7'h63, 7'h14, 7'h08, 7'h14, 7'h63};

   typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

   // Each stage carries {aspersao, gotejamento, freq_matriz}.
   logic [SYNC_STAGES-1:0][2:0] sync_q;
   logic                        freq_prev_q;
   logic                        freq_s;
   logic [1:0]                  mode_s;
   logic                        tick;

   state_t          state_q;
   logic [CW-1:0]   col_q;

   function automatic logic [N_LIN-1:0] glyph(input logic [1:0] m, input logic [CW-1:0] k);
      logic [6:0] g;
      g = 7'h00;
      case (m)
         2'b01:   g = G_TAB[k];
         2'b10:   g = A_TAB[k];
         2'b11:   g = X_TAB[k];
         default: g = 7'h00;
      endcase
      return N_LIN'(g);
   endfunction

   function automatic logic [N_COL-1:0] col_on(input logic [CW-1:0] k);
      logic [N_COL-1:0] w;
      w = N_COL'(1) << k;
      return COL_ACT_LOW ? ~w : w;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q      <= '0;
         freq_prev_q <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], {aspersao, gotejamento, freq_matriz}};
         freq_prev_q <= freq_s;
      end
   end

   assign freq_s = sync_q[SYNC_STAGES-1][0];
   assign mode_s = sync_q[SYNC_STAGES-1][2:1];
   assign tick   = freq_s & ~freq_prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         col_q      <= '0;
         coluna     <= COL_OFF;
         linha      <= '0;
         modo       <= 2'b00;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (tick) begin
                  modo <= mode_s;
                  if (mode_s != 2'b00) begin
                     state_q <= SHOW;
                     col_q   <= '0;
                     coluna  <= col_on('0);
                     linha   <= glyph(mode_s, '0);
                  end
               end
            end
            SHOW: begin
               if (tick) begin
                  state_q <= BLANK;
                  coluna  <= COL_OFF;
                  linha   <= '0;
                  // Frame boundary: the mode for the next frame is taken here.
                  if (col_q == LAST_COL) begin
                     frame_done <= 1'b1;
                     modo       <= mode_s;
                  end
               end
            end
            BLANK: begin
               if (col_q != LAST_COL) begin
                  state_q <= SHOW;
                  col_q   <= col_q + 1'b1;
                  coluna  <= col_on(col_q + 1'b1);
                  linha   <= glyph(modo, col_q + 1'b1);
               end else if (modo != 2'b00) begin
                  state_q <= SHOW;
                  col_q   <= '0;
                  coluna  <= col_on('0);
                  linha   <= glyph(modo, '0);
               end else begin
                  state_q <= IDLE;
                  col_q   <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matriz_scan.sv
// Randomised bench for matriz_scan: a tick-level model of the scanned display
// predicts every column, row pattern, latched mode and frame pulse.
module tb_matriz_scan;

   localparam int N_COL = 5;

   logic       clk         = 1'b0;
   logic       reset       = 1'b1;
   logic       freq_matriz = 1'b0;
   logic       gotejamento = 1'b0;
   logic       aspersao    = 1'b0;
   logic [4:0] coluna;
   logic [6:0] linha;
   logic [1:0] modo;
   logic       frame_done;

   int n_checks = 0;
   int n_errors = 0;
   int fd_seen  = 0;
   int fd_exp   = 0;
   int n_tick   = 0;

   // Reference glyphs indexed [mode][column]: none, G, A, X.
   logic [6:0] gt [4][5] = '{
      '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
      '{7'h3E, 7'h41, 7'h49, 7'h49, 7'h7A},
      '{7'h7E, 7'h09, 7'h09, 7'h09, 7'h7E},
      '{7'h63, 7'h14, 7'h08, 7'h14, 7'h63}
   };

   // Model of what the panel shows: a lit column or nothing.
   bit         m_show;
   int         m_col;
   logic [1:0] m_mode;
   bit         m_fd;

   matriz_scan dut (
      .clk         (clk),
      .reset       (reset),
      .freq_matriz (freq_matriz),
      .gotejamento (gotejamento),
      .aspersao    (aspersao),
      .coluna      (coluna),
      .linha       (linha),
      .modo        (modo),
      .frame_done  (frame_done)
   );

   always #10 clk = ~clk;

   always @(negedge clk) if (!reset && frame_done) fd_seen++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_show = 0;
      m_col  = 0;
      m_mode = 2'b00;
      m_fd   = 0;
   endtask

   task automatic check_disp(input string tag);
      logic [4:0] one;
      logic [4:0] ec;
      logic [6:0] el;
      one = 5'b00001;
      ec  = 5'b11111;
      el  = 7'h00;
      if (m_show) begin
         ec = ~(one << m_col);
         el = gt[m_mode][m_col];
      end
      chk({tag, ".coluna"},     32'(coluna),     32'(ec));
      chk({tag, ".linha"},      32'(linha),      32'(el));
      chk({tag, ".modo"},       32'(modo),       32'(m_mode));
      chk({tag, ".frame_done"}, 32'(frame_done), 32'(m_fd));
   endtask

   task automatic set_mode(input logic a, input logic g);
      aspersao    = a;
      gotejamento = g;
      repeat (3) @(negedge clk);
   endtask

   // freq_matriz was raised just before the next rising edge (E0).
   task automatic tick_body(input int extra_hi, input int lo);
      logic [1:0] mi;
      bit         was_show;
      int         k;
      string      t;
      mi = {aspersao, gotejamento};
      n_tick++;
      t = $sformatf("t%0d", n_tick);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check_disp({t, ".hold"});
      was_show = m_show;
      k        = m_col;
      if (!was_show) begin
         m_mode = mi;
         if (mi != 2'b00) begin
            m_show = 1;
            m_col  = 0;
         end
      end else begin
         m_show = 0;
         if (k == N_COL - 1) begin
            m_fd   = 1;
            m_mode = mi;
            fd_exp++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      check_disp({t, ".e2"});
      m_fd = 0;
      if (was_show) begin
         if (k < N_COL - 1) begin
            m_show = 1;
            m_col  = k + 1;
         end else begin
            m_col  = 0;
            m_show = (m_mode != 2'b00);
         end
      end
      @(posedge clk);
      @(negedge clk);
      check_disp({t, ".e3"});
      $display("tick %0d: mode_in=%b coluna=%b linha=%h modo=%b", n_tick, mi, coluna, linha, modo);
      repeat (extra_hi) @(negedge clk);
      freq_matriz = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic tick(input int extra_hi, input int lo);
      freq_matriz = 1'b1;
      tick_body(extra_hi, lo);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();

      // Reset held while every input toggles.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_disp($sformatf("rst%0d", i));
         freq_matriz = ~freq_matriz;
         gotejamento = 1'($urandom);
         aspersao    = 1'($urandom);
      end
      freq_matriz = 1'b0;
      gotejamento = 1'b0;
      aspersao    = 1'b0;
      reset       = 1'b0;
      repeat (4) @(negedge clk);
      check_disp("idle_after_rst");

      // Drip mode: a full frame plus the wrap back to column 0.
      set_mode(1'b0, 1'b1);
      for (int i = 0; i < 6; i++) tick(2, 4);

      // Switch to sprinkler while column 2 is lit; the G frame must finish.
      tick(2, 4);
      tick(2, 4);
      set_mode(1'b1, 1'b0);
      for (int i = 0; i < 7; i++) tick(1, 5);

      // Both requests: X frame, then both off leads back to IDLE.
      set_mode(1'b1, 1'b1);
      tick(2, 4);
      for (int i = 0; i < 4; i++) tick(2, 4);
      set_mode(1'b0, 1'b0);
      tick(2, 4);
      tick(2, 4);

      // Reset for one cycle while column 3 is lit.
      set_mode(1'b0, 1'b1);
      for (int i = 0; i < 4; i++) tick(2, 4);
      reset = 1'b1;
      @(negedge clk);
      model_reset();
      check_disp("rst_col3");
      reset = 1'b0;
      repeat (2) @(negedge clk);
      tick(2, 4);

      // freq_matriz already high when reset releases: exactly one tick.
      reset       = 1'b1;
      freq_matriz = 1'b1;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      check_disp("rst_freq_hi");
      reset = 1'b0;
      tick_body(6, 5);
      check_disp("one_tick_only");

      // Random mode changes between ticks of varying width.
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 2) == 0)
            set_mode(1'($urandom), 1'($urandom));
         tick(int'($urandom_range(0, 3)), int'($urandom_range(4, 7)));
      end

      chk("frame_done_count", 32'(fd_seen), 32'(fd_exp));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
